relu_pool2: RTL and testbench

Post-convolution stage that consumes the raster-order result stream of the 3x3 convolution block (21-bit signed, qualified by its `En` output). It applies ReLU, 2x2 stride-2 max-pooling and requantization to 9-bit signed. The 9-bit output is the pixel width the next convolution layer accepts. For the default 28-sample lines with 26 valid columns and 26 rows, it emits a 13x13 pooled map per frame.

---
 rtl/relu_pool2.sv | 171 +++++++++++++++++
 tb/tb_relu_pool2.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/relu_pool2.sv
// rtl/relu_pool2.sv - ReLU, 2x2 stride-2 max-pool and requantization of a raster conv stream
//
// Purpose:
//   Consumes the raster-order result stream of the 3x3 convolution block and
//   produces a pooled, requantized pixel stream for the next convolution layer.
//   Negative samples are clamped to zero (ReLU). Each 2x2 window of the kept
//   region is reduced to its maximum, shifted right by SHIFT and saturated to
//   the positive range of a W_OUT-bit signed value.
//
//   Even rows fill a half-width line buffer with horizontal pair maxima. Odd
//   rows combine their own pair maxima with the buffered ones and emit one
//   pixel per pair. Columns at or beyond KEEP are counted but ignored.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous reset, active low
//   in_data     in   W_IN   signed convolution result
//   in_valid    in   1      sample qualifier (convolution block En)
//   out_data    out  W_OUT  pooled pixel, always >= 0, held between strobes
//   out_valid   out  1      one-cycle strobe per pooled pixel
//   out_last    out  1      strobes with the final pooled pixel of a frame
//   frame_done  out  1      one-cycle pulse coincident with out_last
module relu_pool2 #(
   parameter int W_IN  = 21,
   parameter int W_OUT = 9,
   parameter int LINE  = 28,
   parameter int KEEP  = 26,
   parameter int ROWS  = 26,
   parameter int SHIFT = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic signed [W_IN-1:0] in_data,
   input  logic                   in_valid,
   output logic [W_OUT-1:0]       out_data,
   output logic                   out_valid,
   output logic                   out_last,
   output logic                   frame_done
);

   localparam int CW = (LINE > 1) ? $clog2(LINE) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int NB = KEEP / 2;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   // ReLU output never needs the sign bit, so stored values are one bit narrower.
   localparam int VW = W_IN - 1;
   localparam logic [VW-1:0] SAT_MAX = VW'((1 << (W_OUT - 1)) - 1);

   typedef enum logic {
      EVEN_ROW = 1'b0,
      ODD_ROW  = 1'b1
   } phase_e;

   logic [CW-1:0]    col_q, col_d;
   logic [RW-1:0]    row_q, row_d;
   logic [VW-1:0]    p_q, p_d;
   logic [W_OUT-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic             frame_done_q, frame_done_d;

   // Not reset: every entry is rewritten on an even row before an odd row reads it.
   logic [VW-1:0]    line_buf_q [NB];

   phase_e           phase;
   logic             kept;
   logic             odd_col;
   logic             last_col;
   logic             last_row;
   logic             last_pair;
   logic             buf_we;
   logic [IW-1:0]    idx;
   logic [VW-1:0]    r;
   logic [VW-1:0]    m;
   logic [VW-1:0]    b;
   logic [VW-1:0]    v;
   logic [VW-1:0]    q;

   always_comb begin
      // Compare one bit wider so KEEP == LINE == 2^CW still works.
      kept      = ({1'b0, col_q} < (CW + 1)'(KEEP));
      odd_col   = col_q[0];
      last_col  = (col_q == CW'(LINE - 1));
      last_row  = (row_q == RW'(ROWS - 1));
      last_pair = last_row && (col_q == CW'(KEEP - 1));
      phase     = row_q[0] ? ODD_ROW : EVEN_ROW;
      // Index only meaningful for kept columns; the write/emit paths gate on kept.
      idx       = IW'(col_q >> 1);

      r = in_data[W_IN-1] ? '0 : in_data[VW-1:0];
      m = (r > p_q) ? r : p_q;
      b = line_buf_q[idx];
      v = (b > m) ? b : m;
      q = v >> SHIFT;
   end

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      p_d          = p_q;
      buf_we       = 1'b0;
      out_data_d   = out_data_q;
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
      frame_done_d = 1'b0;

      if (in_valid) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end

         if (kept) begin
            if (!odd_col) begin
               p_d = r;
            end else begin
               case (phase)
                  EVEN_ROW: begin
                     buf_we = 1'b1;
                  end
                  ODD_ROW: begin
                     out_data_d  = (q > SAT_MAX) ? SAT_MAX[W_OUT-1:0] : q[W_OUT-1:0];
                     out_valid_d = 1'b1;
                     if (last_pair) begin
                        out_last_d   = 1'b1;
                        frame_done_d = 1'b1;
                     end
                  end
                  default: begin
                     buf_we = 1'b0;
                  end
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         col_q        <= '0;
         row_q        <= '0;
         p_q          <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         p_q          <= p_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (buf_we) begin
         line_buf_q[idx] <= m;
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_pool2.sv
// tb/tb_relu_pool2.sv - directed self-checking bench for relu_pool2 (SHIFT 8 and SHIFT 0 instances)
module tb_relu_pool2;

   localparam int W_IN  = 21;
   localparam int W_OUT = 9;
   localparam int LINE  = 28;
   localparam int KEEP  = 26;
   localparam int ROWS  = 26;
   localparam int NPIX  = (KEEP / 2) * (ROWS / 2);
   localparam int NSAMP = LINE * ROWS;

   localparam int M_RAMP = 0;
   localparam int M_NEG  = 1;
   localparam int M_SAT  = 2;
   localparam int M_DISC = 3;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic signed [W_IN-1:0] in_data = '0;
   logic                   in_valid = 1'b0;

   logic [W_OUT-1:0] od8, od0;
   logic             ov8, ov0, ol8, ol0, fd8, fd0;

   always #5 clk = ~clk;

   relu_pool2 #(.W_IN(W_IN), .W_OUT(W_OUT), .LINE(LINE), .KEEP(KEEP), .ROWS(ROWS), .SHIFT(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .out_data(od8), .out_valid(ov8), .out_last(ol8), .frame_done(fd8)
   );

   relu_pool2 #(.W_IN(W_IN), .W_OUT(W_OUT), .LINE(LINE), .KEEP(KEEP), .ROWS(ROWS), .SHIFT(0)) u_dut0 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .out_data(od0), .out_valid(ov0), .out_last(ol0), .frame_done(fd0)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Output capture
   int unsigned      cyc = 0;
   logic             rst_at_edge = 1'b0;
   logic [W_OUT-1:0] q8[$];
   logic [W_OUT-1:0] q0[$];
   bit               l8[$];
   bit               f8[$];
   bit               l0[$];
   int unsigned      fd_cyc[$];
   int               stray = 0;
   int               hold_err = 0;
   logic [W_OUT-1:0] prev8 = '0;

   always @(posedge clk) begin
      cyc         <= cyc + 1;
      rst_at_edge <= rst;
   end

   always @(negedge clk) begin
      if (rst_at_edge) begin
         if (ov8) begin
            q8.push_back(od8);
            l8.push_back(ol8);
            f8.push_back(fd8);
         end
         if (ov0) begin
            q0.push_back(od0);
            l0.push_back(ol0);
         end
         if (fd8) fd_cyc.push_back(cyc);
         if (!ov8 && (ol8 || fd8)) stray++;
         if (!ov0 && (ol0 || fd0)) stray++;
         if (!ov8 && (od8 !== prev8)) hold_err++;
      end
      prev8 = od8;
   end

   task automatic clear_capture();
      q8.delete();
      q0.delete();
      l8.delete();
      f8.delete();
      l0.delete();
      fd_cyc.delete();
   endtask

   // Stimulus
   function automatic logic signed [W_IN-1:0] sample_val(input int mode, input int r, input int c);
      case (mode)
         M_RAMP:  return W_IN'(10 * c + r);
         M_NEG:   return -21'sd5000;
         M_SAT:   return (r == 6 && c == 10) ? 21'sd300000 : 21'sd0;
         default: return (c >= KEEP) ? 21'sd1048575 : 21'sd0;
      endcase
   endfunction

   // Hand-derived window maxima: ramp window (i,j) peaks at row 2i+1, col 2j+1.
   function automatic int exp_pix(input int mode, input int sh, input int i, input int j);
      int v;
      case (mode)
         M_RAMP: begin
            v = (20 * j + 10 + 2 * i + 1) >> sh;
            return (v > 255) ? 255 : v;
         end
         M_SAT:   return (i == 3 && j == 5) ? 255 : 0;
         default: return 0;
      endcase
   endfunction

   task automatic cycle_in(input logic signed [W_IN-1:0] v, input logic vld);
      in_data  = v;
      in_valid = vld;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle_in('0, 1'b0);
   endtask

   task automatic send_frame(input int mode, input bit gaps, input int nsamp);
      for (int k = 0; k < nsamp; k++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 3));
         cycle_in(sample_val(mode, k / LINE, k % LINE), 1'b1);
      end
   endtask

   task automatic verify_frame(input string tag, input int mode, input int base);
      int ones_l, ones_f;
      if (q8.size() < base + NPIX || q0.size() < base + NPIX) begin
         check({tag, "_short"}, 32'(q8.size()), 32'(base + NPIX));
         return;
      end
      ones_l = 0;
      ones_f = 0;
      for (int i = 0; i < ROWS / 2; i++) begin
         for (int j = 0; j < KEEP / 2; j++) begin
            int k;
            k = base + i * (KEEP / 2) + j;
            check($sformatf("%s_s8_px%0d", tag, k - base), 32'(q8[k]), 32'(exp_pix(mode, 8, i, j)));
            check($sformatf("%s_s0_px%0d", tag, k - base), 32'(q0[k]), 32'(exp_pix(mode, 0, i, j)));
            ones_l += int'(l8[k]);
            ones_f += int'(f8[k]);
         end
      end
      check({tag, "_last_cnt"}, 32'(ones_l), 32'd1);
      check({tag, "_fd_cnt"}, 32'(ones_f), 32'd1);
      check({tag, "_last_pos"}, 32'(l8[base + NPIX - 1]), 32'd1);
      check({tag, "_fd_pos"}, 32'(f8[base + NPIX - 1]), 32'd1);
      check({tag, "_last0_pos"}, 32'(l0[base + NPIX - 1]), 32'd1);
   endtask

   task automatic run_frame(input string tag, input int mode, input bit gaps);
      clear_capture();
      send_frame(mode, gaps, NSAMP);
      idle(4);
      check({tag, "_cnt8"}, 32'(q8.size()), 32'(NPIX));
      check({tag, "_cnt0"}, 32'(q0.size()), 32'(NPIX));
      check({tag, "_fd_pulses"}, 32'(fd_cyc.size()), 32'd1);
      verify_frame(tag, mode, 0);
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(ov8), 32'd0);
      check("rst_out_data", 32'(od8), 32'd0);
      check("rst_out_last", 32'(ol8), 32'd0);
      check("rst_frame_done", 32'(fd8), 32'd0);
      check("rst_out_data_s0", 32'(od0), 32'd0);
      rst = 1'b1;
      idle(2);

      // Ramp: first window max 11 -> 0 at SHIFT 8, 11 at SHIFT 0
      run_frame("ramp", M_RAMP, 1'b0);
      if (q8.size() > 0 && q0.size() > 0) begin
         check("ramp_first_s8", 32'(q8[0]), 32'd0);
         check("ramp_first_s0", 32'(q0[0]), 32'd11);
      end else begin
         check("ramp_first_present", 32'(q8.size()), 32'd1);
      end

      run_frame("neg", M_NEG, 1'b0);
      run_frame("sat", M_SAT, 1'b0);
      run_frame("disc", M_DISC, 1'b0);
      run_frame("gaps", M_RAMP, 1'b1);

      // Reset after 400 samples: rows 0..13 complete -> 7 odd rows x 13 strobes
      clear_capture();
      send_frame(M_RAMP, 1'b0, 400);
      rst = 1'b0;
      cycle_in('0, 1'b0);
      rst = 1'b1;
      check("midrst_no_strobe", 32'(ov8), 32'd0);
      check("midrst_no_strobe_s0", 32'(ov0), 32'd0);
      idle(1);
      check("midrst_no_strobe2", 32'(ov8), 32'd0);
      check("midrst_partial_cnt", 32'(q8.size()), 32'd91);
      run_frame("after_rst", M_RAMP, 1'b0);

      // Back-to-back frames
      clear_capture();
      send_frame(M_RAMP, 1'b0, NSAMP);
      send_frame(M_RAMP, 1'b0, NSAMP);
      idle(4);
      check("b2b_cnt8", 32'(q8.size()), 32'(2 * NPIX));
      check("b2b_fd_pulses", 32'(fd_cyc.size()), 32'd2);
      if (fd_cyc.size() == 2) check("b2b_fd_spacing", 32'(fd_cyc[1] - fd_cyc[0]), 32'(NSAMP));
      verify_frame("b2b_f0", M_RAMP, 0);
      verify_frame("b2b_f1", M_RAMP, NPIX);

      check("stray_flags", 32'(stray), 32'd0);
      check("data_hold", 32'(hold_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
